// File: rtl/a09_io_pkg.sv
// Shared A09 I/O definitions: port FSM state encodings and default sizing
// constants used by the input port and its debouncer.
package a09_io_pkg;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } in_state_e;

  localparam int DEFAULT_DATA_WIDTH      = 16;
  localparam int DEFAULT_IN_WIDTH        = 8;
  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

  // Width of a counter that must reach cycles-1 without wrapping.
  function automatic int debounce_cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/in_port_debounce.sv
// Button conditioner: synchronizer chain, debounce counter, stable level
// and a registered rising-edge pulse. Reusable for any push-button input.
module debounce
  import a09_io_pkg::*;
#(
  parameter int SyncStages     = DEFAULT_SYNC_STAGES,
  parameter int DebounceCycles = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic Clk,
  input  logic Reset,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int CntWidth = debounce_cnt_width(DebounceCycles);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(DebounceCycles - 1);

  logic [SyncStages-1:0] sync_r;
  logic                  synced_s;
  logic [CntWidth-1:0]   cnt_r;
  logic                  stable_r;
  logic                  stable_prev_r;
  logic                  rise_r;

  assign synced_s = sync_r[SyncStages-1];

  // Synchronizer chain: the raw pin feeds the first flop directly.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SyncStages-2:0], raw};
    end
  end

  // Debounce: a differing level must persist DebounceCycles samples to flip stable.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cnt_r    <= '0;
      stable_r <= 1'b0;
    end else if (synced_s == stable_r) begin
      cnt_r    <= '0;
      stable_r <= stable_r;
    end else if (cnt_r == CntMax) begin
      cnt_r    <= '0;
      stable_r <= ~stable_r;
    end else begin
      cnt_r    <= cnt_r + {{(CntWidth-1){1'b0}}, 1'b1};
      stable_r <= stable_r;
    end
  end

  // Registered rise pulse, one edge after stable goes high.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      stable_prev_r <= 1'b0;
      rise_r        <= 1'b0;
    end else begin
      stable_prev_r <= stable_r;
      rise_r        <= stable_r & ~stable_prev_r;
    end
  end

  assign stable = stable_r;
  assign rise   = rise_r;

endmodule

// File: rtl/in_port.sv
// A09 debounced input port: latches synchronized switch pins on each strobe
// press and holds them under a Ready/Ack handshake. IN_PORT_OVERRUN_EN enables
// the sticky Overrun flag; otherwise Overrun is tied low.
module in_port
  import a09_io_pkg::*;
#(
  parameter int DataWidth      = DEFAULT_DATA_WIDTH,
  parameter int InWidth        = DEFAULT_IN_WIDTH,
  parameter int SyncStages     = DEFAULT_SYNC_STAGES,
  parameter int DebounceCycles = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [InWidth-1:0]   PinsIn,
  input  logic                 Strobe,
  input  logic                 Ack,
  output logic [DataWidth-1:0] InReg,
  output logic                 Ready,
  output logic                 Overrun
);

  logic [InWidth-1:0]   pins_sync_r [SyncStages];
  logic [InWidth-1:0]   pins_s;
  logic                 strobe_stable_s;
  logic                 strobe_rise_s;
  logic                 press_s;
  in_state_e            state_r;
  in_state_e            state_nxt_s;
  logic [DataWidth-1:0] in_reg_r;
  logic [DataWidth-1:0] in_reg_nxt_s;
  logic                 overrun_nxt_s;

  // Switch pin synchronizer chain; no logic ahead of the first stage.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < SyncStages; i++) begin
        pins_sync_r[i] <= '0;
      end
    end else begin
      pins_sync_r[0] <= PinsIn;
      for (int i = 1; i < SyncStages; i++) begin
        pins_sync_r[i] <= pins_sync_r[i-1];
      end
    end
  end

  assign pins_s = pins_sync_r[SyncStages-1];

  debounce #(
    .SyncStages     (SyncStages),
    .DebounceCycles (DebounceCycles)
  ) u_strobe_db (
    .Clk    (Clk),
    .Reset  (Reset),
    .raw    (Strobe),
    .stable (strobe_stable_s),
    .rise   (strobe_rise_s)
  );

  // A rise pulse always coincides with a high level; qualifying keeps both outputs meaningful.
  assign press_s = strobe_rise_s & strobe_stable_s;

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      EMPTY: begin
        if (press_s) begin
          state_nxt_s = FULL;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      FULL: begin
        if (Ack && !press_s) begin
          state_nxt_s = EMPTY;
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: begin
        state_nxt_s = EMPTY;
      end
    endcase
  end

  // Output next-value logic for the data register and overrun flag.
  always_comb begin
    in_reg_nxt_s  = in_reg_r;
    overrun_nxt_s = Overrun;
    case (state_r)
      EMPTY: begin
        if (press_s) begin
          in_reg_nxt_s = DataWidth'(pins_s);
        end else begin
          in_reg_nxt_s = in_reg_r;
        end
        if (Ack) begin
          overrun_nxt_s = 1'b0;
        end else begin
          overrun_nxt_s = Overrun;
        end
      end
      FULL: begin
        if (press_s && Ack) begin
          in_reg_nxt_s = DataWidth'(pins_s);
        end else if (press_s) begin
          overrun_nxt_s = 1'b1;
        end else if (Ack) begin
          overrun_nxt_s = 1'b0;
        end else begin
          in_reg_nxt_s = in_reg_r;
        end
      end
      default: begin
        in_reg_nxt_s  = '0;
        overrun_nxt_s = 1'b0;
      end
    endcase
  end

  // Data register; Ready comes straight from the state flop so Ack has no combinational path to it.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      in_reg_r <= '0;
    end else begin
      in_reg_r <= in_reg_nxt_s;
    end
  end

`ifdef IN_PORT_OVERRUN_EN
  logic overrun_r;

  // Sticky overrun flag.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= overrun_nxt_s;
    end
  end

  assign Overrun = overrun_r;
`else
  logic overrun_unused_s;
  assign overrun_unused_s = overrun_nxt_s;
  assign Overrun          = 1'b0;
`endif

  assign InReg = in_reg_r;
  assign Ready = (state_r == FULL);

endmodule

// File: tb/tb_in_port.sv
// Directed self-checking bench for in_port with SyncStages=2, DebounceCycles=4
// (press-to-Ready latency of 8 cycles).
module tb_in_port;

  logic        Clk;
  logic        Reset;
  logic [7:0]  PinsIn;
  logic        Strobe;
  logic        Ack;
  logic [15:0] InReg;
  logic        Ready;
  logic        Overrun;

  int chk_cnt  = 0;
  int pass_cnt = 0;

`ifdef IN_PORT_OVERRUN_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  in_port #(
    .DataWidth      (16),
    .InWidth        (8),
    .SyncStages     (2),
    .DebounceCycles (4)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .PinsIn  (PinsIn),
    .Strobe  (Strobe),
    .Ack     (Ack),
    .InReg   (InReg),
    .Ready   (Ready),
    .Overrun (Overrun)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic ack_pulse();
    Ack = 1'b1;
    tick(1);
    Ack = 1'b0;
  endtask

  task automatic release_strobe();
    Strobe = 1'b0;
    tick(12);
  endtask

  task automatic test_reset();
    Reset = 1'b0; Strobe = 1'b1; PinsIn = 8'hA5; Ack = 1'b0;
    tick(3);
    chk_cnt++; if (InReg !== 16'h0000) $display("FAIL reset_inreg: got %h expected %h", InReg, 16'h0000); else pass_cnt++;
    chk_cnt++; if (Ready !== 1'b0) $display("FAIL reset_ready: got %b expected %b", Ready, 1'b0); else pass_cnt++;
    chk_cnt++; if (Overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected %b", Overrun, 1'b0); else pass_cnt++;
    Reset = 1'b1;
    tick(7);
    chk_cnt++; if (Ready !== 1'b0) $display("FAIL reset_held_early: got %b expected %b", Ready, 1'b0); else pass_cnt++;
    tick(1);
    chk_cnt++; if (Ready !== 1'b1) $display("FAIL reset_held_ready: got %b expected %b", Ready, 1'b1); else pass_cnt++;
    chk_cnt++; if (InReg !== 16'h00A5) $display("FAIL reset_held_inreg: got %h expected %h", InReg, 16'h00A5); else pass_cnt++;
    // Reset while FULL discards everything; held button must debounce again.
    Reset = 1'b0;
    tick(1);
    chk_cnt++; if (Ready !== 1'b0 || InReg !== 16'h0000) $display("FAIL reset_in_full: got %b/%h expected 0/0000", Ready, InReg); else pass_cnt++;
    Reset = 1'b1;
    tick(7);
    chk_cnt++; if (Ready !== 1'b0) $display("FAIL rereset_early: got %b expected %b", Ready, 1'b0); else pass_cnt++;
    tick(1);
    chk_cnt++; if (Ready !== 1'b1) $display("FAIL rereset_ready: got %b expected %b", Ready, 1'b1); else pass_cnt++;
    ack_pulse();
    release_strobe();
  endtask

  task automatic test_clean_press();
    PinsIn = 8'h3C;
    tick(3);
    Strobe = 1'b1;
    tick(7);
    chk_cnt++; if (Ready !== 1'b0) $display("FAIL clean_early: got %b expected %b", Ready, 1'b0); else pass_cnt++;
    tick(1);
    chk_cnt++; if (Ready !== 1'b1) $display("FAIL clean_ready: got %b expected %b", Ready, 1'b1); else pass_cnt++;
    chk_cnt++; if (InReg !== 16'h003C) $display("FAIL clean_inreg: got %h expected %h", InReg, 16'h003C); else pass_cnt++;
    Ack = 1'b1;
    #2;
    chk_cnt++; if (Ready !== 1'b1) $display("FAIL clean_ack_comb: got %b expected %b", Ready, 1'b1); else pass_cnt++;
    tick(1);
    Ack = 1'b0;
    chk_cnt++; if (Ready !== 1'b0) $display("FAIL clean_ack_ready: got %b expected %b", Ready, 1'b0); else pass_cnt++;
    chk_cnt++; if (InReg !== 16'h003C) $display("FAIL clean_ack_inreg: got %h expected %h", InReg, 16'h003C); else pass_cnt++;
    release_strobe();
  endtask

  task automatic test_bounce();
    PinsIn = 8'h5A;
    tick(3);
    Strobe = 1'b1; tick(1);
    Strobe = 1'b0; tick(1);
    Strobe = 1'b1; tick(1);
    Strobe = 1'b0; tick(1);
    Strobe = 1'b1;
    tick(7);
    chk_cnt++; if (Ready !== 1'b0) $display("FAIL bounce_early: got %b expected %b", Ready, 1'b0); else pass_cnt++;
    tick(1);
    chk_cnt++; if (Ready !== 1'b1) $display("FAIL bounce_ready: got %b expected %b", Ready, 1'b1); else pass_cnt++;
    chk_cnt++; if (InReg !== 16'h005A) $display("FAIL bounce_inreg: got %h expected %h", InReg, 16'h005A); else pass_cnt++;
    ack_pulse();
    tick(12);
    chk_cnt++; if (Ready !== 1'b0) $display("FAIL bounce_single_event: got %b expected %b", Ready, 1'b0); else pass_cnt++;
    release_strobe();
  endtask

  task automatic test_overrun();
    PinsIn = 8'h11;
    tick(3);
    Strobe = 1'b1;
    tick(8);
    chk_cnt++; if (Ready !== 1'b1 || InReg !== 16'h0011) $display("FAIL ovr_first: got %b/%h expected 1/0011", Ready, InReg); else pass_cnt++;
    release_strobe();
    PinsIn = 8'h22;
    tick(3);
    Strobe = 1'b1;
    tick(8);
    chk_cnt++; if (InReg !== 16'h0011) $display("FAIL ovr_inreg_kept: got %h expected %h", InReg, 16'h0011); else pass_cnt++;
    chk_cnt++; if (Ready !== 1'b1) $display("FAIL ovr_ready: got %b expected %b", Ready, 1'b1); else pass_cnt++;
    chk_cnt++; if (Overrun !== OVR_EXP) $display("FAIL ovr_flag: got %b expected %b", Overrun, OVR_EXP); else pass_cnt++;
    ack_pulse();
    chk_cnt++; if (Ready !== 1'b0) $display("FAIL ovr_ack_ready: got %b expected %b", Ready, 1'b0); else pass_cnt++;
    chk_cnt++; if (Overrun !== 1'b0) $display("FAIL ovr_ack_clear: got %b expected %b", Overrun, 1'b0); else pass_cnt++;
    release_strobe();
  endtask

  task automatic test_ack_with_press();
    PinsIn = 8'h11;
    tick(3);
    Strobe = 1'b1;
    tick(8);
    chk_cnt++; if (Ready !== 1'b1) $display("FAIL same_first_ready: got %b expected %b", Ready, 1'b1); else pass_cnt++;
    release_strobe();
    PinsIn = 8'h33;
    tick(3);
    Strobe = 1'b1;
    tick(7);
    Ack = 1'b1;
    tick(1);
    Ack = 1'b0;
    chk_cnt++; if (InReg !== 16'h0033) $display("FAIL same_inreg: got %h expected %h", InReg, 16'h0033); else pass_cnt++;
    chk_cnt++; if (Ready !== 1'b1) $display("FAIL same_ready: got %b expected %b", Ready, 1'b1); else pass_cnt++;
    chk_cnt++; if (Overrun !== 1'b0) $display("FAIL same_overrun: got %b expected %b", Overrun, 1'b0); else pass_cnt++;
    tick(1);
    chk_cnt++; if (Ready !== 1'b1) $display("FAIL same_ready_hold: got %b expected %b", Ready, 1'b1); else pass_cnt++;
    ack_pulse();
    release_strobe();
  endtask

  task automatic test_ack_empty();
    ack_pulse();
    tick(1);
    chk_cnt++; if (Ready !== 1'b0) $display("FAIL empty_ack_ready: got %b expected %b", Ready, 1'b0); else pass_cnt++;
    chk_cnt++; if (InReg !== 16'h0033) $display("FAIL empty_ack_inreg: got %h expected %h", InReg, 16'h0033); else pass_cnt++;
    Ack = 1'b1;
    tick(3);
    Ack = 1'b0;
    chk_cnt++; if (Ready !== 1'b0 || Overrun !== 1'b0) $display("FAIL empty_ack_level: got %b/%b expected 0/0", Ready, Overrun); else pass_cnt++;
    chk_cnt++; if (InReg !== 16'h0033) $display("FAIL empty_ack_level_inreg: got %h expected %h", InReg, 16'h0033); else pass_cnt++;
  endtask

  initial begin
    Reset = 1'b0; Strobe = 1'b0; PinsIn = 8'h00; Ack = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_overrun();
    test_ack_with_press();
    test_ack_empty();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
